// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   instr_req_op    fetch request, held with its address until granted
//   instr_addr_op   word-aligned fetch address
//   instr_gnt_ip    memory accepted the request this cycle
//   instr_rvalid_ip read data valid (at most one response per accepted request)
//   instr_rdata_ip  read data
// master: fetch side, slave: memory side.
interface fetch_stage_if;
  logic        instr_req_op;
  logic [31:0] instr_addr_op;
  logic        instr_gnt_ip;
  logic        instr_rvalid_ip;
  logic [31:0] instr_rdata_ip;

  modport master (
    output instr_req_op,
    output instr_addr_op,
    input  instr_gnt_ip,
    input  instr_rvalid_ip,
    input  instr_rdata_ip
  );

  modport slave (
    input  instr_req_op,
    input  instr_addr_op,
    output instr_gnt_ip,
    output instr_rvalid_ip,
    output instr_rdata_ip
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core.
// Issues one word fetch at a time over req/gnt/rvalid, buffers responses in a
// 2-entry prefetch FIFO and hands one instruction per cycle to decode.
// Ports:
//   clk, reset      core clock (rising edge), asynchronous active-high reset
//   stall_ip        hold IF/ID register (FIFO may keep filling)
//   flush_ip        kill fetched stream, restart at redirect_pc_ip (beats stall)
//   redirect_pc_ip  redirect target, low two bits ignored
//   imem            instruction-memory bus (master side)
//   ID_instr_op     instruction in IF/ID, NOP_INSTR when not valid
//   ID_pc_op        PC of ID_instr_op
//   ID_valid_op     ID_instr_op is a real instruction
module fetch_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_ip,
  input  logic                 flush_ip,
  input  logic [31:0]          redirect_pc_ip,
  fetch_stage_if.master        imem,
  output logic [31:0]          ID_instr_op,
  output logic [31:0]          ID_pc_op,
  output logic                 ID_valid_op
);

  // Pointers are one bit wide, so the buffer only works with two entries.
  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_pc_q    [2];

  logic        req, gnt_acc, push, pop, bypass, fifo_wr;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc_ip & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;

    // Only REQ has nothing in flight, so a free slot now is a free slot when
    // the response lands.
    req     = (state_q == S_REQ) && (count_q < DEPTH);
    gnt_acc = req && imem.instr_gnt_ip;
    push    = (state_q == S_WAIT) && imem.instr_rvalid_ip && !flush_ip;
    pop     = !flush_ip && !stall_ip && (count_q != 2'd0);
    // Empty FIFO: a response goes straight into IF/ID, saving a cycle.
    bypass  = !flush_ip && !stall_ip && (count_q == 2'd0) && push;
    fifo_wr = push && !bypass;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (gnt_acc) begin
          state_d     = S_WAIT;
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT:    if (imem.instr_rvalid_ip) state_d = S_REQ;
      S_DISCARD: if (imem.instr_rvalid_ip) state_d = S_REQ;
    endcase

    if (flush_ip) begin
      fetch_pc_d = redirect_aligned;
      unique case (state_q)
        S_IDLE:    state_d = S_REQ;
        // A request granted in the flush cycle still owes us a response.
        S_REQ:     state_d = gnt_acc ? S_DISCARD : S_REQ;
        // A response arriving in the flush cycle itself is simply not pushed.
        S_WAIT:    state_d = imem.instr_rvalid_ip ? S_REQ : S_DISCARD;
        S_DISCARD: state_d = imem.instr_rvalid_ip ? S_REQ : S_DISCARD;
      endcase
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q ^ fifo_wr;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, fifo_wr} - {1'b0, pop};
      if (stall_ip) begin
        id_instr_d = id_instr_q;
      end else if (pop) begin
        id_instr_d = fifo_instr_q[rd_ptr_q];
        id_pc_d    = fifo_pc_q[rd_ptr_q];
        id_valid_d = 1'b1;
      end else if (bypass) begin
        id_instr_d = imem.instr_rdata_ip;
        id_pc_d    = issued_pc_q;
        id_valid_d = 1'b1;
      end else begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= BOOT_ADDR;
      issued_pc_q <= BOOT_ADDR;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= BOOT_ADDR;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_instr_q[wr_ptr_q] <= imem.instr_rdata_ip;
      fifo_pc_q[wr_ptr_q]    <= issued_pc_q;
    end
  end

  // The request rule reserves a slot, so a response can never meet a full FIFO.
  assert property (@(posedge clk) disable iff (reset)
    !((state_q == S_WAIT) && imem.instr_rvalid_ip && (count_q == DEPTH)));

  assign imem.instr_req_op  = req;
  assign imem.instr_addr_op = fetch_pc_q;
  assign ID_instr_op        = id_instr_q;
  assign ID_pc_op           = id_pc_q;
  assign ID_valid_op        = id_valid_q;

endmodule
